// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Frame length math lives here so the arbiter and its users agree.
package uart_pkg;

    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } uart_arb_state_t;

    // Cycles from the first enable cycle to the last busy cycle.
    function automatic int frame_cycles(
        input int fre,
        input int bps,
        input int guard
    );
        return FRAME_BITS * (fre / bps + 1) + 2 + guard;
    endfunction

    // Bits needed to index 'value' distinct states (at least 1).
    function automatic int calculateBitWidth(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle of the UART transmit arbiter.
// The master side drives requests; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   i_req;
    logic [NUM_REQ*8-1:0] i_data;
    logic [NUM_REQ-1:0]   o_ack;
    logic [7:0]           o_tx_data;
    logic                 o_tx_en;
    logic                 o_busy;
    logic [IW-1:0]        o_grant_id;

    modport master (
        output i_req,
        output i_data,
        input  o_ack,
        input  o_tx_data,
        input  o_tx_en,
        input  o_busy,
        input  o_grant_id
    );

    modport slave (
        input  i_req,
        input  i_data,
        output o_ack,
        output o_tx_data,
        output o_tx_en,
        output o_busy,
        output o_grant_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr,
// wrapping around, returned as one-hot, index and valid flag.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         valid
);

    int         c;
    logic [W-1:0] ci;

    // Scan upward from ptr and keep the first hit.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        ci    = '0;
        for (int i = 0; i < N; i++) begin
            c  = (int'(ptr) + i) % N;
            ci = W'(c);
            if (!valid && req[ci]) begin
                valid   = 1'b1;
                idx     = ci;
                gnt[ci] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among byte sources.
// Frames are paced by an internal timer instead of the tx busy flag.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int FRE_CLK      = 100_000_000,
    parameter int UART_BPS     = 115200,
    parameter int EN_HOLD      = 4,
    parameter int GUARD_CYCLES = 4
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int FRAME_CYC =
        frame_cycles(FRE_CLK, UART_BPS, GUARD_CYCLES);
    localparam int TW = calculateBitWidth(FRAME_CYC + 1);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [TW-1:0] T_EN_LAST  = TW'(EN_HOLD - 1);
    localparam logic [TW-1:0] T_FRM_LAST = TW'(FRAME_CYC - 1);
    localparam logic [IW-1:0] ID_LAST    = IW'(NUM_REQ - 1);

    uart_arb_state_t state_q, state_d;

    logic [TW-1:0]      timer_q, timer_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gid_q, gid_d;
    logic [7:0]         data_q, data_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_vld;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req   (bus.i_req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    // State, timer and grant registers; reset clears a frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            data_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    // Grant in IDLE, hold enable in SEND, run out the frame in WAIT.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                timer_d = timer_q;
                if (pick_vld) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (pick_gnt[k]) begin
                            data_d = bus.i_data[8*k +: 8];
                        end
                    end
                    gid_d   = pick_idx;
                    ack_d   = pick_gnt;
                    ptr_d   = (pick_idx == ID_LAST) ?
                              '0 : pick_idx + IW'(1);
                    timer_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (timer_q == T_EN_LAST) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (timer_q == T_FRM_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_tx_en    = (state_q == SEND);
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.o_ack      = ack_q;
    assign bus.o_tx_data  = data_q;
    assign bus.o_grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for the UART transmit arbiter.
// A 4-requester and a 1-requester instance share clock and reset.
module tb_uart_tx_arbiter;

    localparam int FRAME   = 10 * (1000 / 100 + 1) + 2 + 4;
    localparam int SPACING = FRAME + 1;
    localparam int BOUND   = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   m_ptr = 0;

    logic [7:0] d [4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter_if #(.NUM_REQ(4)) if4 ();
    uart_tx_arbiter_if #(.NUM_REQ(1)) if1 ();

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .FRE_CLK      (1000),
        .UART_BPS     (100),
        .EN_HOLD      (4),
        .GUARD_CYCLES (4)
    ) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    uart_tx_arbiter #(
        .NUM_REQ      (1),
        .FRE_CLK      (1000),
        .UART_BPS     (100),
        .EN_HOLD      (4),
        .GUARD_CYCLES (4)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    function automatic int rr_pick(logic [3:0] req, int ptr);
        for (int off = 0; off < 4; off++) begin
            if (req[(ptr + off) % 4]) return (ptr + off) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(int k);
        logic [3:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic pack4();
        if4.i_data = {d[3], d[2], d[1], d[0]};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if4.i_req = '0;
        if4.i_data = '0;
        if1.i_req = '0;
        if1.i_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic wait_ack4(output bit to);
        to = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (if4.o_ack != 0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle4(output bit to);
        to = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (!if4.o_busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic measure4(output int en, output int busy,
                            output int acks, output bit to);
        en = 0; busy = 0; acks = 0; to = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            if (!if4.o_busy) begin
                to = 1'b0;
                break;
            end
            en += int'(if4.o_tx_en);
            busy++;
            acks += (if4.o_ack != 0) ? 1 : 0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if4.i_req = '0;
        if4.i_data = '0;
        if1.i_req = '0;
        if1.i_data = '0;
        @(negedge clk);
        total++;
        if ({if4.o_ack, if4.o_tx_en, if4.o_busy, if4.o_grant_id} !== '0) begin
            bad++;
            $display("FAIL reset_ctl got ack=%b en=%b busy=%b gid=%0d want 0",
                     if4.o_ack, if4.o_tx_en, if4.o_busy, if4.o_grant_id);
        end
        total++;
        if (if4.o_tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data got %h want 00", if4.o_tx_data);
        end
        total++;
        if ({if1.o_ack, if1.o_tx_en, if1.o_busy, if1.o_tx_data} !== '0) begin
            bad++;
            $display("FAIL reset_one got ack=%b en=%b busy=%b data=%h want 0",
                     if1.o_ack, if1.o_tx_en, if1.o_busy, if1.o_tx_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit to;
        int c0, en, busy, acks;
        do_reset();
        d = '{8'h55, 8'h00, 8'h00, 8'h00};
        pack4();
        if4.i_req = 4'b0001;
        c0 = cyc;
        wait_ack4(to);
        if4.i_req = '0;
        total++;
        if (to || (cyc - c0) != 1) begin
            bad++;
            $display("FAIL single_lat got %0d want 1 (to=%0d)", cyc - c0, to);
        end
        total++;
        if (if4.o_ack !== 4'b0001 || if4.o_grant_id !== 2'd0) begin
            bad++;
            $display("FAIL single_ack got ack=%b gid=%0d want 0001/0",
                     if4.o_ack, if4.o_grant_id);
        end
        total++;
        if (if4.o_tx_data !== 8'h55 || if4.o_tx_en !== 1'b1) begin
            bad++;
            $display("FAIL single_data got %h en=%b want 55/1",
                     if4.o_tx_data, if4.o_tx_en);
        end
        measure4(en, busy, acks, to);
        total++;
        if (to || en != 4 || busy != FRAME || acks != 1) begin
            bad++;
            $display("FAIL single_frame got en=%0d busy=%0d acks=%0d want 4/%0d/1",
                     en, busy, acks, FRAME);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int prev, exp;
        do_reset();
        d = '{8'h10, 8'h11, 8'h12, 8'h13};
        pack4();
        if4.i_req = 4'hF;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ack4(to);
            exp = rr_pick(4'hF, m_ptr);
            m_ptr = (exp + 1) % 4;
            total++;
            if (to) begin
                bad++;
                $display("FAIL b2b_timeout frame %0d got no ack want ack", k);
                break;
            end
            total++;
            if (if4.o_ack !== onehot(exp) || int'(if4.o_grant_id) != exp ||
                if4.o_tx_data !== d[exp] || if4.o_tx_en !== 1'b1) begin
                bad++;
                $display("FAIL b2b_grant %0d got ack=%b gid=%0d data=%h want gid=%0d data=%h",
                         k, if4.o_ack, if4.o_grant_id, if4.o_tx_data, exp, d[exp]);
            end
            if (k > 0) begin
                total++;
                if (cyc - prev != SPACING) begin
                    bad++;
                    $display("FAIL b2b_spacing %0d got %0d want %0d",
                             k, cyc - prev, SPACING);
                end
            end
            prev = cyc;
        end
        if4.i_req = '0;
        wait_idle4(to);
    endtask

    task automatic test_priority();
        bit to;
        do_reset();
        d = '{8'h20, 8'h00, 8'h22, 8'h00};
        pack4();
        if4.i_req = 4'b0001;
        wait_ack4(to);
        if4.i_req = '0;
        wait_idle4(to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL prio_idle got busy want idle");
        end
        if4.i_req = 4'b0101;
        wait_ack4(to);
        if4.i_req = 4'b0001;
        total++;
        if (to || if4.o_ack !== 4'b0100 || if4.o_tx_data !== 8'h22) begin
            bad++;
            $display("FAIL prio_first got ack=%b data=%h want 0100/22",
                     if4.o_ack, if4.o_tx_data);
        end
        wait_ack4(to);
        if4.i_req = '0;
        total++;
        if (to || if4.o_grant_id !== 2'd0 || if4.o_tx_data !== 8'h20) begin
            bad++;
            $display("FAIL prio_second got gid=%0d data=%h want 0/20",
                     if4.o_grant_id, if4.o_tx_data);
        end
        wait_idle4(to);
    endtask

    task automatic test_reset_midframe();
        bit to;
        int c0, en, busy, acks;
        do_reset();
        d = '{8'h00, 8'h3C, 8'h00, 8'hA5};
        pack4();
        if4.i_req = 4'b0010;
        wait_ack4(to);
        if4.i_req = '0;
        repeat (50) @(negedge clk);
        total++;
        if (to || if4.o_busy !== 1'b1 || if4.o_tx_en !== 1'b0) begin
            bad++;
            $display("FAIL mid_wait got busy=%b en=%b want 1/0",
                     if4.o_busy, if4.o_tx_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({if4.o_ack, if4.o_tx_en, if4.o_busy, if4.o_tx_data} !== '0) begin
            bad++;
            $display("FAIL mid_async got ack=%b en=%b busy=%b data=%h want 0",
                     if4.o_ack, if4.o_tx_en, if4.o_busy, if4.o_tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        if4.i_req = 4'b1000;
        c0 = cyc;
        wait_ack4(to);
        if4.i_req = '0;
        total++;
        if (to || (cyc - c0) != 1 || if4.o_ack !== 4'b1000 ||
            if4.o_grant_id !== 2'd3 || if4.o_tx_data !== 8'hA5) begin
            bad++;
            $display("FAIL mid_after got lat=%0d ack=%b gid=%0d data=%h want 1/1000/3/a5",
                     cyc - c0, if4.o_ack, if4.o_grant_id, if4.o_tx_data);
        end
        measure4(en, busy, acks, to);
        total++;
        if (to || en != 4 || busy != FRAME || acks != 1) begin
            bad++;
            $display("FAIL mid_frame got en=%0d busy=%0d acks=%0d want 4/%0d/1",
                     en, busy, acks, FRAME);
        end
    endtask

    task automatic test_pulse_wait();
        bit to;
        int acks, tail_busy, tail_ack;
        do_reset();
        d = '{8'h77, 8'h99, 8'h00, 8'h00};
        pack4();
        if4.i_req = 4'b0001;
        wait_ack4(to);
        if4.i_req = '0;
        repeat (20) @(negedge clk);
        if4.i_req = 4'b0010;
        @(negedge clk);
        if4.i_req = '0;
        acks = 0;
        to = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            if (!if4.o_busy) begin
                to = 1'b0;
                break;
            end
            acks += (if4.o_ack != 0) ? 1 : 0;
            @(negedge clk);
        end
        tail_busy = 0;
        tail_ack = 0;
        for (int i = 0; i < 10; i++) begin
            tail_busy += int'(if4.o_busy);
            tail_ack += (if4.o_ack != 0) ? 1 : 0;
            @(negedge clk);
        end
        total++;
        if (to || acks != 0) begin
            bad++;
            $display("FAIL pulse_ack got acks=%0d to=%0d want 0/0", acks, to);
        end
        total++;
        if (tail_busy != 0 || tail_ack != 0) begin
            bad++;
            $display("FAIL pulse_idle got busy=%0d ack=%0d want 0/0",
                     tail_busy, tail_ack);
        end
    endtask

    task automatic test_random();
        bit to;
        int exp;
        logic [3:0] mask;
        do_reset();
        for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
        mask = 4'($urandom_range(15, 1));
        pack4();
        if4.i_req = mask;
        for (int f = 0; f < 12; f++) begin
            exp = rr_pick(mask, m_ptr);
            wait_ack4(to);
            total++;
            if (to || if4.o_ack !== onehot(exp) ||
                int'(if4.o_grant_id) != exp || if4.o_tx_data !== d[exp]) begin
                bad++;
                $display("FAIL rand_grant %0d got ack=%b gid=%0d data=%h want gid=%0d data=%h",
                         f, if4.o_ack, if4.o_grant_id, if4.o_tx_data, exp, d[exp]);
                break;
            end
            m_ptr = (exp + 1) % 4;
            if ($urandom_range(1, 0) == 1) mask[exp] = 1'b0;
            else d[exp] = 8'($urandom);
            for (int k = 0; k < 4; k++) begin
                if (!mask[k] && $urandom_range(3, 0) == 0) begin
                    mask[k] = 1'b1;
                    d[k] = 8'($urandom);
                end
            end
            if (mask == 0) begin
                exp = int'($urandom_range(3, 0));
                mask[exp] = 1'b1;
            end
            pack4();
            if4.i_req = mask;
        end
        if4.i_req = '0;
        wait_idle4(to);
    endtask

    task automatic test_single_req();
        bit to;
        int prev;
        do_reset();
        if1.i_data = 8'hFF;
        if1.i_req = 1'b1;
        prev = 0;
        for (int f = 0; f < 3; f++) begin
            to = 1'b1;
            for (int i = 0; i < BOUND; i++) begin
                @(negedge clk);
                if (if1.o_ack != 0) begin
                    to = 1'b0;
                    break;
                end
            end
            total++;
            if (to || if1.o_ack !== 1'b1 || if1.o_grant_id !== 1'b0 ||
                if1.o_tx_data !== 8'hFF || if1.o_tx_en !== 1'b1) begin
                bad++;
                $display("FAIL one_grant %0d got ack=%b gid=%0d data=%h en=%b want 1/0/ff/1",
                         f, if1.o_ack, if1.o_grant_id, if1.o_tx_data, if1.o_tx_en);
                break;
            end
            if (f > 0) begin
                total++;
                if (cyc - prev != SPACING) begin
                    bad++;
                    $display("FAIL one_spacing %0d got %0d want %0d",
                             f, cyc - prev, SPACING);
                end
            end
            prev = cyc;
        end
        if1.i_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_priority();
        test_reset_midframe();
        test_pulse_wait();
        test_random();
        test_single_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
